// File: rtl/hex_display_ctrl.sv
// Registered 7-segment driver for NDIGITS hex digits: frame-aligned (tear-free) update,
// leading-zero blanking, per-digit blink and PWM brightness dimming. Segments are active-low.
module hex_display_ctrl #(
    parameter int NDIGITS   = 6,
    parameter int PWM_BITS  = 4,
    parameter int BLINK_DIV = 12_500_000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [4*NDIGITS-1:0]   value,
    input  logic                   load,
    input  logic                   blank_lz,
    input  logic [NDIGITS-1:0]     blink_mask,
    input  logic [PWM_BITS-1:0]    brightness,
    output logic [7*NDIGITS-1:0]   hex_seg,
    output logic                   upd,
    output logic                   blink_phase
);

    localparam int                  BLINK_W    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BLINK_W-1:0]  BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
    localparam logic [PWM_BITS-1:0] PWM_LAST   = '1;

    logic [4*NDIGITS-1:0] shadow_q, shadow_d;
    logic [4*NDIGITS-1:0] active_q, active_d;
    logic                 pending_q, pending_d;
    logic [PWM_BITS-1:0]  pwm_cnt_q, pwm_cnt_d;
    logic [BLINK_W-1:0]   blink_cnt_q, blink_cnt_d;
    logic                 blink_phase_q, blink_phase_d;
    logic                 upd_q, upd_d;
    logic [7*NDIGITS-1:0] hex_seg_q, hex_seg_d;

    logic                 transfer;
    logic                 lit;
    logic                 all_zero;
    logic [NDIGITS-1:0]   lz_blank;

    function automatic logic [6:0] seg_pattern(input logic [3:0] nibble);
        logic [6:0] seg;
        case (nibble)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

    // A load coinciding with a transfer hands the old shadow to active and keeps the new one pending.
    always_comb begin
        transfer      = pending_q && (pwm_cnt_q == PWM_LAST);
        shadow_d      = load ? value : shadow_q;
        pending_d     = load | (pending_q & ~transfer);
        active_d      = transfer ? shadow_q : active_q;
        upd_d         = transfer;
        pwm_cnt_d     = pwm_cnt_q + PWM_BITS'(1);
        blink_cnt_d   = blink_cnt_q + BLINK_W'(1);
        blink_phase_d = blink_phase_q;
        if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d   = '0;
            blink_phase_d = ~blink_phase_q;
        end
    end

    // Leading-zero scan runs from the most significant digit down; digit 0 always shows.
    always_comb begin
        lit       = (brightness == PWM_LAST) || (pwm_cnt_q < brightness);
        all_zero  = 1'b1;
        lz_blank  = '0;
        hex_seg_d = '1;
        for (int i = NDIGITS - 1; i >= 0; i--) begin
            all_zero    = all_zero & (active_q[4*i +: 4] == 4'h0);
            lz_blank[i] = blank_lz & all_zero & (i != 0);
        end
        for (int i = 0; i < NDIGITS; i++) begin
            if (lit && !lz_blank[i] && !(blink_phase_q && blink_mask[i])) begin
                hex_seg_d[7*i +: 7] = seg_pattern(active_q[4*i +: 4]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_q      <= '0;
            active_q      <= '0;
            pending_q     <= 1'b0;
            pwm_cnt_q     <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            upd_q         <= 1'b0;
            hex_seg_q     <= '1;
        end else begin
            shadow_q      <= shadow_d;
            active_q      <= active_d;
            pending_q     <= pending_d;
            pwm_cnt_q     <= pwm_cnt_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            upd_q         <= upd_d;
            hex_seg_q     <= hex_seg_d;
        end
    end

    assign hex_seg     = hex_seg_q;
    assign upd         = upd_q;
    assign blink_phase = blink_phase_q;

endmodule
